// File: rtl/host_write_buffer_m_pkg.sv
// Shared constants for the host posted-write buffer: dummy bus address,
// default depth and the retire FSM encoding.
package host_write_buffer_m_pkg;

  localparam int          HWB_DEPTH       = 4;
  localparam logic [15:0] HOST_DUMMY_ADDR = 16'h8000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARM   = 2'd1,
    ST_DRIVE = 2'd2,
    ST_HOLD  = 2'd3
  } hwb_state_e;

endpackage

// File: rtl/host_write_buffer_m_if.sv
// CPU-side write port and BBC host-bus pins of the posted-write buffer.
interface host_write_buffer_m_if #(
  parameter int AW = 16,
  parameter int DW = 8
);
  logic          wr_req;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          cpu_rdy;

  logic [AW-1:0] bbc_addr;
  logic [DW-1:0] bbc_data_o;
  logic          bbc_data_oe;
  logic          bbc_rnw;

  modport master (
    output wr_req, wr_addr, wr_data,
    input  cpu_rdy, bbc_addr, bbc_data_o, bbc_data_oe, bbc_rnw
  );

  modport slave (
    input  wr_req, wr_addr, wr_data,
    output cpu_rdy, bbc_addr, bbc_data_o, bbc_data_oe, bbc_rnw
  );
endinterface

// File: rtl/host_write_buffer_m_sync_fifo.sv
// Small synchronous FIFO holding {addr,data} write entries; level is the
// pointer difference with an extra MSB so full and empty are unambiguous.
module sync_fifo_m #(
  parameter int DEPTH = 4,
  parameter int W     = 24
) (
  input  logic                   bbc_ck8,
  input  logic                   resetb,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           dout,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [PW:0] PTR_ONE = {{PW{1'b0}}, 1'b1};

  logic [DEPTH-1:0][W-1:0] mem;
  logic [PW:0]             wr_ptr;
  logic [PW:0]             rd_ptr;

  always_ff @(posedge bbc_ck8 or negedge resetb) begin
    if (!resetb) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push)          wr_ptr <= wr_ptr + PTR_ONE;
      if (pop && !empty) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage needs no reset: only slots between the pointers are ever read.
  always_ff @(posedge bbc_ck8) begin
    if (push) mem[wr_ptr[PW-1:0]] <= din;
  end

  assign dout  = mem[rd_ptr[PW-1:0]];
  assign level = wr_ptr - rd_ptr;
  assign full  = (level == LW'(DEPTH));
  assign empty = (level == '0);

endmodule

// File: rtl/host_write_buffer_m.sv
// Posted-write buffer: queues host writes at CPU speed and retires them one
// per 2MHz host cycle, aligned to phi0 via a two-flop phase detector.
module host_write_buffer_m
  import host_write_buffer_m_pkg::*;
#(
  parameter int DEPTH = HWB_DEPTH,
  parameter int AW    = 16,
  parameter int DW    = 8
) (
  input  logic                   bbc_ck8,
  input  logic                   resetb,
  input  logic                   bbc_ck2_phi0,
  input  logic                   block_host_wr,
  host_write_buffer_m_if.slave   bus,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  output logic                   busy
);
  localparam int LW = $clog2(DEPTH) + 1;
  localparam logic [AW-1:0] DUMMY = AW'(HOST_DUMMY_ADDR);

  logic phi0_q, phi0_qq, rise, fall;
  logic push, pop, blocked;

  logic [AW+DW-1:0] head;
  logic [AW-1:0]    head_addr;
  logic [DW-1:0]    head_data;

  hwb_state_e    state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;
  logic          rnw_q, rnw_d;
  logic          oe_q, oe_d;

  always_ff @(posedge bbc_ck8 or negedge resetb) begin
    if (!resetb) begin
      phi0_q  <= 1'b0;
      phi0_qq <= 1'b0;
    end else begin
      phi0_q  <= bbc_ck2_phi0;
      phi0_qq <= phi0_q;
    end
  end

  assign rise = phi0_q & ~phi0_qq;
  assign fall = ~phi0_q & phi0_qq;

  // A push into a full buffer still lands if the head retires on this edge.
  assign push = bus.wr_req & (~full | pop);

  sync_fifo_m #(
    .DEPTH (DEPTH),
    .W     (AW + DW)
  ) u_fifo (
    .bbc_ck8 (bbc_ck8),
    .resetb  (resetb),
    .push    (push),
    .pop     (pop),
    .din     ({bus.wr_addr, bus.wr_data}),
    .dout    (head),
    .level   (level),
    .full    (full),
    .empty   (empty)
  );

  assign head_addr = head[AW+DW-1:DW];
  assign head_data = head[DW-1:0];

  always_ff @(posedge bbc_ck8 or negedge resetb) begin
    if (!resetb) overflow <= 1'b0;
    else if (bus.wr_req && full && !pop) overflow <= 1'b1;
  end

  assign bus.cpu_rdy = ~(full & bus.wr_req);
  assign busy        = (state_q != ST_IDLE) | ~empty;

  always_ff @(posedge bbc_ck8 or negedge resetb) begin
    if (!resetb) begin
      state_q <= ST_IDLE;
      addr_q  <= DUMMY;
      data_q  <= '0;
      rnw_q   <= 1'b1;
      oe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      rnw_q   <= rnw_d;
      oe_q    <= oe_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    rnw_d   = rnw_q;
    oe_d    = oe_q;
    pop     = 1'b0;
    // Low-memory writes suppressed by the map register still burn a host cycle.
    blocked = block_host_wr & ~head_addr[AW-1];
    unique case (state_q)
      ST_IDLE: begin
        rnw_d  = 1'b1;
        oe_d   = 1'b0;
        addr_d = DUMMY;
        if (!empty) state_d = ST_ARM;
      end
      ST_ARM: begin
        addr_d = head_addr;
        data_d = head_data;
        if (rise) begin
          state_d = ST_DRIVE;
          rnw_d   = blocked;
          oe_d    = ~blocked;
        end
      end
      ST_DRIVE: begin
        if (fall) begin
          state_d = ST_HOLD;
          rnw_d   = 1'b1;
        end
      end
      ST_HOLD: begin
        pop     = 1'b1;
        rnw_d   = 1'b1;
        oe_d    = 1'b0;
        addr_d  = DUMMY;
        state_d = (level > LW'(1)) ? ST_ARM : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.bbc_addr    = addr_q;
  assign bus.bbc_data_o  = data_q;
  assign bus.bbc_data_oe = oe_q;
  assign bus.bbc_rnw     = rnw_q;

endmodule
